// File: rtl/cat_move_ctrl.sv
// cat_move_ctrl: picks the cat's next cell on the offset-row hex board.
// It reads the six neighbours one at a time from a synchronous board RAM and
// keeps the free neighbour closest to the board edge. If the cat already sits
// on the border it reports Escaped. If every neighbour is blocked it reports
// Trapped.
module cat_move_ctrl #(
   parameter int GRID_W  = 11,
   parameter int GRID_H  = 11,
   parameter int COORD_W = 4,
   parameter int ADDR_W  = 7
) (
   input  logic               ClkPort,
   input  logic               Reset_n,
   input  logic               MoveStart,
   input  logic [COORD_W-1:0] CatRow,
   input  logic [COORD_W-1:0] CatCol,
   output logic               BoardRdEn,
   output logic [ADDR_W-1:0]  BoardAddr,
   input  logic               BoardRdData,
   output logic               Busy,
   output logic               MoveDone,
   output logic [COORD_W-1:0] NextRow,
   output logic [COORD_W-1:0] NextCol,
   output logic               Escaped,
   output logic               Trapped
);

   // Each neighbour k gets one read cycle (RD) and one evaluate cycle (EV).
   // idx_q selects which neighbour is being read or evaluated.
   typedef enum logic [2:0] {IDLE, CHECK, RD, EV, DONE} state_e;

   localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);
   localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(GRID_H - 1);
   localparam logic [COORD_W-1:0] LAST_COL = COORD_W'(GRID_W - 1);
   localparam logic [2:0]         LAST_NBR = 3'd5;

   // Neighbour k of (r,c), returned as {row,col}. Odd rows are shifted right,
   // so the diagonal columns depend on the row parity.
   function automatic logic [2*COORD_W-1:0] nbrOf(input logic [COORD_W-1:0] r,
                                                  input logic [COORD_W-1:0] c,
                                                  input logic [2:0] k);
      logic [COORD_W-1:0] nr;
      logic [COORD_W-1:0] nc;
      nr = r;
      nc = c;
      case (k)
         3'd0: nc = c + ONE;
         3'd1: nc = c - ONE;
         3'd2: begin nr = r - ONE; nc = r[0] ? c + ONE : c;       end
         3'd3: begin nr = r - ONE; nc = r[0] ? c       : c - ONE; end
         3'd4: begin nr = r + ONE; nc = r[0] ? c + ONE : c;       end
         3'd5: begin nr = r + ONE; nc = r[0] ? c       : c - ONE; end
         default: ;
      endcase
      return {nr, nc};
   endfunction

   // Distance to the nearest board edge. Smaller values are closer to escape.
   function automatic logic [COORD_W-1:0] edgeDist(input logic [COORD_W-1:0] r,
                                                   input logic [COORD_W-1:0] c);
      logic [COORD_W-1:0] d;
      d = r;
      if (LAST_ROW - r < d) d = LAST_ROW - r;
      if (c < d)            d = c;
      if (LAST_COL - c < d) d = LAST_COL - c;
      return d;
   endfunction

   function automatic logic [ADDR_W-1:0] addrOf(input logic [COORD_W-1:0] r,
                                                input logic [COORD_W-1:0] c);
      return ADDR_W'(r) * ADDR_W'(GRID_W) + ADDR_W'(c);
   endfunction

   state_e             state_q,     state_d;
   logic [2:0]         idx_q,       idx_d;
   logic [COORD_W-1:0] catRow_q,    catRow_d;
   logic [COORD_W-1:0] catCol_q,    catCol_d;
   logic [COORD_W-1:0] bestRow_q,   bestRow_d;
   logic [COORD_W-1:0] bestCol_q,   bestCol_d;
   logic [COORD_W-1:0] bestScore_q, bestScore_d;
   logic               found_q,     found_d;
   logic [ADDR_W-1:0]  addr_q,      addr_d;
   logic [COORD_W-1:0] nextRow_q,   nextRow_d;
   logic [COORD_W-1:0] nextCol_q,   nextCol_d;
   logic               escaped_q,   escaped_d;
   logic               trapped_q,   trapped_d;

   logic [2:0]           nxtIdx;
   logic [2*COORD_W-1:0] curNbr;
   logic [2*COORD_W-1:0] nxtNbr;
   logic [COORD_W-1:0]   curScore;
   logic                 catOnEdge;

   // State and datapath registers; reset aborts any search in progress.
   always_ff @(posedge ClkPort or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         catRow_q    <= '0;
         catCol_q    <= '0;
         bestRow_q   <= '0;
         bestCol_q   <= '0;
         bestScore_q <= '0;
         found_q     <= 1'b0;
         addr_q      <= '0;
         nextRow_q   <= '0;
         nextCol_q   <= '0;
         escaped_q   <= 1'b0;
         trapped_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         catRow_q    <= catRow_d;
         catCol_q    <= catCol_d;
         bestRow_q   <= bestRow_d;
         bestCol_q   <= bestCol_d;
         bestScore_q <= bestScore_d;
         found_q     <= found_d;
         addr_q      <= addr_d;
         nextRow_q   <= nextRow_d;
         nextCol_q   <= nextCol_d;
         escaped_q   <= escaped_d;
         trapped_q   <= trapped_d;
      end
   end

   // Next-state logic: walk the six neighbours and keep the best free one.
   // Ties keep the lowest k because only a strictly lower score replaces it.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      catRow_d    = catRow_q;
      catCol_d    = catCol_q;
      bestRow_d   = bestRow_q;
      bestCol_d   = bestCol_q;
      bestScore_d = bestScore_q;
      found_d     = found_q;
      addr_d      = addr_q;
      nextRow_d   = nextRow_q;
      nextCol_d   = nextCol_q;
      escaped_d   = escaped_q;
      trapped_d   = trapped_q;

      nxtIdx    = (state_q == CHECK) ? 3'd0 : idx_q + 3'd1;
      curNbr    = nbrOf(catRow_q, catCol_q, idx_q);
      nxtNbr    = nbrOf(catRow_q, catCol_q, nxtIdx);
      curScore  = edgeDist(curNbr[2*COORD_W-1:COORD_W], curNbr[COORD_W-1:0]);
      catOnEdge = (catRow_q == '0) || (catCol_q == '0) ||
                  (catRow_q >= LAST_ROW) || (catCol_q >= LAST_COL);

      case (state_q)
         IDLE: begin
            if (MoveStart) begin
               catRow_d    = CatRow;
               catCol_d    = CatCol;
               escaped_d   = 1'b0;
               trapped_d   = 1'b0;
               found_d     = 1'b0;
               bestScore_d = '0;
               bestRow_d   = '0;
               bestCol_d   = '0;
               idx_d       = '0;
               state_d     = CHECK;
            end
         end
         CHECK: begin
            if (catOnEdge) begin
               escaped_d = 1'b1;
               nextRow_d = catRow_q;
               nextCol_d = catCol_q;
               state_d   = DONE;
            end else begin
               idx_d   = nxtIdx;
               addr_d  = addrOf(nxtNbr[2*COORD_W-1:COORD_W], nxtNbr[COORD_W-1:0]);
               state_d = RD;
            end
         end
         RD: begin
            state_d = EV;
         end
         EV: begin
            if (!BoardRdData && (!found_q || (curScore < bestScore_q))) begin
               found_d     = 1'b1;
               bestRow_d   = curNbr[2*COORD_W-1:COORD_W];
               bestCol_d   = curNbr[COORD_W-1:0];
               bestScore_d = curScore;
            end
            if (idx_q == LAST_NBR) begin
               state_d = DONE;
               if (found_d) begin
                  nextRow_d = bestRow_d;
                  nextCol_d = bestCol_d;
               end else begin
                  trapped_d = 1'b1;
                  nextRow_d = catRow_q;
                  nextCol_d = catCol_q;
               end
            end else begin
               idx_d   = nxtIdx;
               addr_d  = addrOf(nxtNbr[2*COORD_W-1:COORD_W], nxtNbr[COORD_W-1:0]);
               state_d = RD;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign Busy      = (state_q != IDLE);
   assign MoveDone  = (state_q == DONE);
   assign BoardRdEn = (state_q == RD);
   assign BoardAddr = addr_q;
   assign NextRow   = nextRow_q;
   assign NextCol   = nextCol_q;
   assign Escaped   = escaped_q;
   assign Trapped   = trapped_q;

endmodule

// File: tb/tb_cat_move_ctrl.sv
// Testbench for cat_move_ctrl: board RAM model, reference move picker and
// directed plus randomized move requests.
module tb_cat_move_ctrl;

   logic       ClkPort = 1'b0;
   logic       Reset_n = 1'b0;
   logic       MoveStart = 1'b0;
   logic [3:0] CatRow = '0;
   logic [3:0] CatCol = '0;
   logic       BoardRdEn;
   logic [6:0] BoardAddr;
   logic       BoardRdData = 1'b0;
   logic       Busy;
   logic       MoveDone;
   logic [3:0] NextRow;
   logic [3:0] NextCol;
   logic       Escaped;
   logic       Trapped;

   int errors = 0;
   int checks = 0;

   logic blocked [0:127];

   int expR, expC;
   int expEsc, expTrap;
   int expAddrQ[$];

   cat_move_ctrl #(.GRID_W(11), .GRID_H(11), .COORD_W(4), .ADDR_W(7)) dut (
      .ClkPort    (ClkPort),
      .Reset_n    (Reset_n),
      .MoveStart  (MoveStart),
      .CatRow     (CatRow),
      .CatCol     (CatCol),
      .BoardRdEn  (BoardRdEn),
      .BoardAddr  (BoardAddr),
      .BoardRdData(BoardRdData),
      .Busy       (Busy),
      .MoveDone   (MoveDone),
      .NextRow    (NextRow),
      .NextCol    (NextCol),
      .Escaped    (Escaped),
      .Trapped    (Trapped)
   );

   // Free-running clock, 10 time units per cycle.
   always #5 ClkPort = ~ClkPort;

   // Synchronous board RAM: data appears the cycle after the read strobe.
   always @(posedge ClkPort) begin
      if (BoardRdEn) BoardRdData <= blocked[BoardAddr];
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int edgeDistRef(input int r, input int c);
      int d;
      d = r;
      if (10 - r < d) d = 10 - r;
      if (c < d) d = c;
      if (10 - c < d) d = 10 - c;
      return d;
   endfunction

   // Reference move picker written from the hex-board rules: neighbour offsets
   // come from row parity tables, the free neighbour with the smallest edge
   // distance wins and the first one seen wins a tie.
   task automatic modelMove(input int r, input int c);
      int dRow[6]     = '{0, 0, -1, -1, 1, 1};
      int dColEven[6] = '{1, -1, 0, -1, 0, -1};
      int dColOdd[6]  = '{1, -1, 1, 0, 1, 0};
      int best, bestScore, nr, nc, s;
      expAddrQ.delete();
      expEsc  = 0;
      expTrap = 0;
      expR    = r;
      expC    = c;
      if (r >= 10 || c >= 10 || r == 0 || c == 0) begin
         expEsc = 1;
         return;
      end
      best = -1;
      bestScore = 1000;
      for (int k = 0; k < 6; k++) begin
         nr = r + dRow[k];
         nc = c + ((r % 2 == 1) ? dColOdd[k] : dColEven[k]);
         expAddrQ.push_back(nr * 11 + nc);
         if (!blocked[nr * 11 + nc]) begin
            s = edgeDistRef(nr, nc);
            if (best < 0 || s < bestScore) begin
               best = k;
               bestScore = s;
               expR = nr;
               expC = nc;
            end
         end
      end
      if (best < 0) begin
         expTrap = 1;
         expR = r;
         expC = c;
      end
   endtask

   task automatic clearBoard();
      for (int a = 0; a < 128; a++) blocked[a] = 1'b0;
   endtask

   // One full move request checked against the reference model. With
   // pokeBusy set, extra MoveStart pulses are thrown in mid-search and on the
   // MoveDone cycle; none of them may be accepted.
   task automatic applyStimulus(input int r, input int c, input bit pokeBusy, input string tag);
      int cyc, doneCyc;
      int rdCyc[$];
      int rdAddr[$];
      logic [3:0] gotR, gotC;
      logic gotEsc, gotTrap;
      bit busyOk;
      modelMove(r, c);
      @(negedge ClkPort);
      CatRow = 4'(r);
      CatCol = 4'(c);
      MoveStart = 1'b1;
      @(posedge ClkPort);
      cyc = 0;
      doneCyc = -1;
      busyOk = 1'b1;
      gotR = '0; gotC = '0; gotEsc = 1'b0; gotTrap = 1'b0;
      while (doneCyc < 0 && cyc < 40) begin
         @(negedge ClkPort);
         MoveStart = 1'b0;
         CatRow = 4'(r);
         CatCol = 4'(c);
         cyc++;
         if (!Busy) busyOk = 1'b0;
         if (BoardRdEn) begin
            rdCyc.push_back(cyc);
            rdAddr.push_back(int'(BoardAddr));
         end
         if (MoveDone) begin
            doneCyc = cyc;
            gotR = NextRow; gotC = NextCol; gotEsc = Escaped; gotTrap = Trapped;
         end
         if (pokeBusy && (cyc == 5 || MoveDone)) begin
            MoveStart = 1'b1;
            CatRow = 4'd0;
            CatCol = 4'd0;
         end
      end
      checkOutput({tag, "/doneCycle"}, doneCyc, expEsc ? 2 : 14);
      checkOutput({tag, "/busy"}, busyOk, 1);
      checkOutput({tag, "/readCount"}, rdCyc.size(), expAddrQ.size());
      for (int i = 0; i < rdCyc.size() && i < expAddrQ.size(); i++) begin
         checkOutput($sformatf("%s/readCycle%0d", tag, i), rdCyc[i], 2 * i + 2);
         checkOutput($sformatf("%s/readAddr%0d", tag, i), rdAddr[i], expAddrQ[i]);
      end
      checkOutput({tag, "/escaped"}, gotEsc, expEsc);
      checkOutput({tag, "/trapped"}, gotTrap, expTrap);
      if (!expEsc) begin
         checkOutput({tag, "/nextRow"}, gotR, expR);
         checkOutput({tag, "/nextCol"}, gotC, expC);
      end
      @(negedge ClkPort);
      MoveStart = 1'b0;
      checkOutput({tag, "/idleBusy"}, Busy, 0);
      checkOutput({tag, "/idleDone"}, MoveDone, 0);
      checkOutput({tag, "/heldFlags"}, {Escaped, Trapped}, {gotEsc, gotTrap});
      checkOutput({tag, "/heldNext"}, {NextRow, NextCol}, {gotR, gotC});
   endtask

   initial begin
      int cyc, doneSeen, r, c;
      clearBoard();

      // Reset state
      #12;
      checkOutput("reset/outputs",
                  {Busy, MoveDone, BoardRdEn, BoardAddr, NextRow, NextCol, Escaped, Trapped}, 0);
      @(negedge ClkPort);
      Reset_n = 1'b1;

      // Empty board, cat in the middle: all scores tie, east wins
      applyStimulus(5, 5, 1'b0, "empty55");

      // East blocked: west is next in order with the same score
      blocked[61] = 1'b1;
      applyStimulus(5, 5, 1'b0, "eastBlocked55");
      clearBoard();

      // Even row near the top edge: NE is closest
      applyStimulus(2, 5, 1'b0, "empty25");
      blocked[16] = 1'b1;
      applyStimulus(2, 5, 1'b0, "neBlocked25");
      clearBoard();

      // All six neighbours blocked
      foreach (blocked[a]) blocked[a] = 1'b0;
      blocked[61] = 1'b1; blocked[59] = 1'b1; blocked[50] = 1'b1;
      blocked[49] = 1'b1; blocked[72] = 1'b1; blocked[71] = 1'b1;
      applyStimulus(5, 5, 1'b0, "trapped55");
      clearBoard();

      // Border and out-of-range cats escape without reading the board
      applyStimulus(0, 3, 1'b0, "escape03");
      applyStimulus(12, 2, 1'b0, "escape122");

      // Reset in the middle of the fourth read
      @(negedge ClkPort);
      CatRow = 4'd5;
      CatCol = 4'd5;
      MoveStart = 1'b1;
      @(posedge ClkPort);
      for (cyc = 1; cyc <= 8; cyc++) begin
         @(negedge ClkPort);
         MoveStart = 1'b0;
      end
      checkOutput("abort/rd3Strobe", BoardRdEn, 1);
      checkOutput("abort/rd3Addr", BoardAddr, 49);
      Reset_n = 1'b0;
      #1;
      checkOutput("abort/outputs",
                  {Busy, MoveDone, BoardRdEn, BoardAddr, NextRow, NextCol, Escaped, Trapped}, 0);
      repeat (3) @(negedge ClkPort);
      Reset_n = 1'b1;
      doneSeen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge ClkPort);
         if (MoveDone || Busy) doneSeen++;
      end
      checkOutput("abort/noDone", doneSeen, 0);

      // Fresh start after the abort, with ignored MoveStart pulses while busy
      applyStimulus(5, 5, 1'b1, "afterAbort55");

      // Randomized boards and cat positions
      for (int it = 0; it < 12; it++) begin
         for (int a = 0; a < 128; a++) blocked[a] = ($urandom_range(0, 99) < 40);
         if (it % 4 == 3) begin
            r = int'($urandom_range(0, 12));
            c = int'($urandom_range(0, 12));
         end else begin
            r = int'($urandom_range(1, 9));
            c = int'($urandom_range(1, 9));
         end
         applyStimulus(r, c, it[0], $sformatf("rand%0d", it));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cat_move_ctrl.md
Name: cat_move_ctrl

Overview:
- Sequencer that computes the cat's next move on the hex board after each player turn.
- Started by the top-level game FSM from its PLAY state once a block has been placed.
- Reads the six neighbour cells from the board RAM one at a time and picks the free neighbour closest to the edge.
- Reports Escaped (cat already on the border, so the player loses) or Trapped (no free neighbour, so the player wins).

Parameters:
- GRID_W, 11, board columns.
- GRID_H, 11, board rows.
- COORD_W, 4, row/column coordinate width.
- ADDR_W, 7, board RAM address width; must be at least ceil(log2(GRID_W*GRID_H)).

Ports:
- ClkPort  in  1  system clock; all state changes on its rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- MoveStart  in  1  single-cycle request; accepted only in IDLE.
- CatRow  in  COORD_W  current cat row; sampled on accept.
- CatCol  in  COORD_W  current cat column; sampled on accept.
- BoardRdEn  out  1  board RAM read strobe.
- BoardAddr  out  ADDR_W  board RAM address = row*GRID_W + col.
- BoardRdData  in  1  1 = cell blocked; valid the cycle after BoardRdEn (synchronous RAM).
- Busy  out  1  high from accept until MoveDone, inclusive.
- MoveDone  out  1  single-cycle pulse; results valid from this cycle until the next accept.
- NextRow  out  COORD_W  chosen cell row.
- NextCol  out  COORD_W  chosen cell column.
- Escaped  out  1  cat is on the border or out of range; no move.
- Trapped  out  1  all six neighbours are blocked; no move.

Behaviour:
- Reset (async, Reset_n=0):
  - State goes to IDLE.
  - All outputs are 0; internal best/score registers are cleared.
  - Reset mid-operation aborts the search with no MoveDone.
- Geometry:
  - Offset-row hex; odd rows are shifted right.
  - Neighbour order k=0..5: E(r,c+1), W(r,c-1), NE, NW, SE, SW.
  - Even r: NE=(r-1,c), NW=(r-1,c-1), SE=(r+1,c), SW=(r+1,c-1).
  - Odd r: NE=(r-1,c+1), NW=(r-1,c), SE=(r+1,c+1), SW=(r+1,c).
- Score: edge distance = min(r, GRID_H-1-r, c, GRID_W-1-c). Compute it unsigned, in COORD_W bits.
- States and transitions:
  - IDLE → CHECK when MoveStart=1. CatRow and CatCol are latched; Busy rises next cycle.
  - CHECK: if the cat is on the border or out of range (row ≥ GRID_H or col ≥ GRID_W), set Escaped=1 and go to DONE. Otherwise go to RD0. Since the cat is interior, every neighbour is in-grid.
  - RDk: BoardRdEn=1, BoardAddr = address of neighbour k. Go to EVk.
  - EVk: BoardRdEn=0, BoardAddr held. If BoardRdData=0 and this is the first free neighbour, or its score is strictly below the best so far, update best. Ties keep the lowest k. EVk goes to RD(k+1); EV5 goes to DONE.
  - DONE: MoveDone=1. If no free neighbour was found, set Trapped=1 and hold NextRow/NextCol at the cat position. Otherwise drive NextRow/NextCol with the best neighbour. Go to IDLE.
- Latency, counting the accept edge as cycle 0:
  - Escape: MoveDone in cycle 2.
  - Full search: MoveDone in cycle 14, with exactly 6 BoardRdEn pulses at cycles 2, 4, …, 12.
- Flags:
  - Escaped and Trapped are mutually exclusive.
  - Both clear on the next accept.
  - Outputs are held stable in IDLE.
- MoveStart while Busy is ignored and not queued. MoveStart in the same cycle as DONE is also ignored; it is only accepted in IDLE.
- Single requester: the board RAM port is owned by this block while Busy.

Test Plan:
- Empty board, cat (5,5), MoveStart → six reads at cycles 2–12; MoveDone cycle 14; Next=(5,6) (all scores 4, E wins tie); Escaped=0, Trapped=0.
- Same, with (5,6) blocked → Next=(5,4). BoardAddr sequence is 61, 59, 50, 49, 72, 71.
- Empty board, cat (2,5) → Next=(1,5) (NE, score 1, address 16). With (1,5) blocked → Next=(1,4).
- Cat (5,5) with all six neighbours blocked → Trapped=1, Next=(5,5), MoveDone cycle 14.
- Cat (0,3), and separately cat (12,2) → Escaped=1; MoveDone cycle 2; BoardRdEn never asserted.
- Reset_n low during RD3 → all outputs 0 immediately, no MoveDone. Then: MoveStart pulses while Busy are ignored, and a fresh start from (5,5) completes normally at cycle 14.
